// File: rtl/riscv_mem_arbiter.sv
// Shares one 64-bit word-addressed memory port between instruction fetch and the
// load/store unit, with fixed LS priority, an IF starvation guard and RV64 lane handling.
module riscv_mem_arbiter #(
  parameter int STARVE_LIM = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_if_req,
  input  logic [63:0] i_if_addr,
  output logic        o_if_ready,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  output logic        o_if_err,
  input  logic        i_ls_req,
  input  logic        i_ls_we,
  input  logic [63:0] i_ls_addr,
  input  logic [1:0]  i_ls_size,
  input  logic        i_ls_unsigned,
  input  logic [63:0] i_ls_wdata,
  output logic        o_ls_ready,
  output logic        o_ls_rvalid,
  output logic [63:0] o_ls_rdata,
  output logic        o_ls_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [60:0] o_mem_addr,
  output logic [7:0]  o_mem_be,
  output logic [63:0] o_mem_wdata,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [63:0] i_mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_REQ, S_WAIT_R, S_RESP} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_own_ls;
  logic               r_we;
  logic               r_uns;
  logic               r_if_hi;
  logic [1:0]         r_size;
  logic [2:0]         r_off;
  logic               r_mem_req;
  logic               r_mem_we;
  logic [60:0]        r_mem_addr;
  logic [7:0]         r_mem_be;
  logic [63:0]        r_mem_wdata;
  logic               r_if_rvalid;
  logic               r_if_err;
  logic [31:0]        r_if_rdata;
  logic               r_ls_rvalid;
  logic               r_ls_err;
  logic [63:0]        r_ls_rdata;

  logic               w_idle;
  logic               w_force_if;
  logic               w_pick_ls;
  logic               w_pick_if;
  logic [7:0]         w_be_base;
  logic [63:0]        w_wmask;
  logic [2:0]         w_align;
  logic [7:0]         w_be;
  logic [63:0]        w_wdata;
  logic               w_ls_mis;
  logic               w_if_mis;
  logic [63:0]        w_shift;
  logic               w_sx;
  logic [63:0]        w_load;
  logic [31:0]        w_fetch;

  assign w_idle     = (r_state == S_IDLE);
  assign w_force_if = i_if_req && (r_cnt == CNT_W'(STARVE_LIM));
  assign w_pick_ls  = i_ls_req && !w_force_if;
  assign w_pick_if  = i_if_req && !w_pick_ls;

  // Ready is gated by rst_n so every output reads 0 while reset is held.
  assign o_ls_ready = rst_n && w_idle && w_pick_ls;
  assign o_if_ready = rst_n && w_idle && w_pick_if;

  always_comb begin
    w_be_base = 8'hFF;
    w_wmask   = '1;
    w_align   = 3'b111;
    case (i_ls_size)
      2'd0: begin w_be_base = 8'h01; w_wmask = 64'h0000_0000_0000_00FF; w_align = 3'b000; end
      2'd1: begin w_be_base = 8'h03; w_wmask = 64'h0000_0000_0000_FFFF; w_align = 3'b001; end
      2'd2: begin w_be_base = 8'h0F; w_wmask = 64'h0000_0000_FFFF_FFFF; w_align = 3'b011; end
      default: begin w_be_base = 8'hFF; w_wmask = '1; w_align = 3'b111; end
    endcase
  end

  assign w_be     = w_be_base << i_ls_addr[2:0];
  assign w_wdata  = (i_ls_wdata & w_wmask) << {i_ls_addr[2:0], 3'b000};
  assign w_ls_mis = |(i_ls_addr[2:0] & w_align);
  assign w_if_mis = |i_if_addr[1:0];

  assign w_shift = i_mem_rdata >> {r_off, 3'b000};
  assign w_sx    = ~r_uns;
  assign w_fetch = r_if_hi ? i_mem_rdata[63:32] : i_mem_rdata[31:0];

  always_comb begin
    w_load = w_shift;
    case (r_size)
      2'd0:    w_load = {{56{w_sx & w_shift[7]}},  w_shift[7:0]};
      2'd1:    w_load = {{48{w_sx & w_shift[15]}}, w_shift[15:0]};
      2'd2:    w_load = {{32{w_sx & w_shift[31]}}, w_shift[31:0]};
      default: w_load = w_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_own_ls    <= 1'b0;
      r_we        <= 1'b0;
      r_uns       <= 1'b0;
      r_if_hi     <= 1'b0;
      r_size      <= 2'd0;
      r_off       <= 3'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 8'h00;
      r_mem_wdata <= '0;
      r_if_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rvalid <= 1'b0;
      r_ls_err    <= 1'b0;
      r_ls_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_ls) begin
            r_own_ls <= 1'b1;
            r_we     <= i_ls_we;
            r_uns    <= i_ls_unsigned;
            r_size   <= i_ls_size;
            r_off    <= i_ls_addr[2:0];
            if (!i_if_req)
              r_cnt <= '0;
            else if (r_cnt != CNT_W'(STARVE_LIM))
              r_cnt <= r_cnt + 1'b1;
            if (w_ls_mis) begin
              r_state     <= S_ERR;
              r_ls_rvalid <= 1'b1;
              r_ls_err    <= 1'b1;
              r_ls_rdata  <= '0;
            end else begin
              r_state     <= S_REQ;
              r_mem_req   <= 1'b1;
              r_mem_we    <= i_ls_we;
              r_mem_addr  <= i_ls_addr[63:3];
              r_mem_be    <= i_ls_we ? w_be : 8'hFF;
              r_mem_wdata <= i_ls_we ? w_wdata : 64'd0;
            end
          end else if (w_pick_if) begin
            r_own_ls <= 1'b0;
            r_we     <= 1'b0;
            r_if_hi  <= i_if_addr[2];
            r_cnt    <= '0;
            if (w_if_mis) begin
              r_state     <= S_ERR;
              r_if_rvalid <= 1'b1;
              r_if_err    <= 1'b1;
              r_if_rdata  <= '0;
            end else begin
              r_state     <= S_REQ;
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= i_if_addr[63:3];
              r_mem_be    <= 8'hFF;
              r_mem_wdata <= 64'd0;
            end
          end
        end
        S_ERR: begin
          r_if_rvalid <= 1'b0;
          r_if_err    <= 1'b0;
          r_ls_rvalid <= 1'b0;
          r_ls_err    <= 1'b0;
          r_state     <= S_IDLE;
        end
        S_REQ: begin
          if (i_mem_gnt) begin
            r_mem_req <= 1'b0;
            if (r_we) begin
              r_state     <= S_RESP;
              r_ls_rvalid <= 1'b1;
              r_ls_rdata  <= '0;
            end else begin
              r_state <= S_WAIT_R;
            end
          end
        end
        S_WAIT_R: begin
          if (i_mem_rvalid) begin
            r_state <= S_RESP;
            if (r_own_ls) begin
              r_ls_rvalid <= 1'b1;
              r_ls_rdata  <= w_load;
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= w_fetch;
            end
          end
        end
        S_RESP: begin
          r_if_rvalid <= 1'b0;
          r_ls_rvalid <= 1'b0;
          r_if_rdata  <= '0;
          r_ls_rdata  <= '0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_if_rvalid = r_if_rvalid;
  assign o_if_err    = r_if_err;
  assign o_if_rdata  = r_if_rdata;
  assign o_ls_rvalid = r_ls_rvalid;
  assign o_ls_err    = r_ls_err;
  assign o_ls_rdata  = r_ls_rdata;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_be    = r_mem_be;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: directed and randomized transactions against a
// byte-array memory model with random grant/read-data delays.
module tb_riscv_mem_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_ready, if_rvalid, if_err;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we, ls_unsigned, ls_ready, ls_rvalid, ls_err;
  logic [63:0] ls_addr, ls_wdata, ls_rdata;
  logic [1:0]  ls_size;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [60:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata, mem_rdata;
  logic [236:0] all_out;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] mem_b [0:127];

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    logic [7:0]  be;
    logic [63:0] wd;
    logic [60:0] maddr;
    logic        mwe;
    bit          mem_seen, unstable, rv_after, other_rv, busy_ready, timeout;
    int          lat;
  } obs_t;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.STARVE_LIM(LIM), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ready(if_ready),
    .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata), .o_if_err(if_err),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_size(ls_size),
    .i_ls_unsigned(ls_unsigned), .i_ls_wdata(ls_wdata), .o_ls_ready(ls_ready),
    .o_ls_rvalid(ls_rvalid), .o_ls_rdata(ls_rdata), .o_ls_err(ls_err),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_be(mem_be),
    .o_mem_wdata(mem_wdata), .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  assign all_out = {if_ready, if_rvalid, if_rdata, if_err, ls_ready, ls_rvalid, ls_rdata, ls_err,
                    mem_req, mem_we, mem_addr, mem_be, mem_wdata};

  // Memory model: 16 words of 8 bytes, selected by word index bits [3:0].
  function automatic logic [63:0] word_at(input logic [3:0] w);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = mem_b[{w, 3'(i)}];
    return v;
  endfunction

  task automatic set_word(input int w, input logic [63:0] v);
    for (int i = 0; i < 8; i++) mem_b[w*8+i] = v[8*i +: 8];
  endtask

  function automatic bit ref_mis(input bit is_ls, input logic [63:0] a, input logic [1:0] sz);
    if (is_ls) return (int'(a[2:0]) % (1 << sz)) != 0;
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] sz, input bit uns);
    int n = 1 << sz;
    int o = int'(a[2:0]);
    int w = int'(a[6:3]);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mem_b[w*8+o+i];
    if (!uns && n < 8 && v[8*n-1]) for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] ref_be(input logic [63:0] a, input logic [1:0] sz);
    logic [7:0] b = '0;
    for (int i = 0; i < (1 << sz); i++) b[int'(a[2:0])+i] = 1'b1;
    return b;
  endfunction

  function automatic logic [63:0] ref_wd(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] d);
    logic [63:0] r = '0;
    for (int i = 0; i < (1 << sz); i++) r[8*(int'(a[2:0])+i) +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic apply_store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] d);
    for (int i = 0; i < (1 << sz); i++) mem_b[int'(a[6:3])*8 + int'(a[2:0]) + i] = d[8*i +: 8];
  endtask

  // Runs one transaction end to end, playing the memory with the given delays; records observations.
  task automatic run_txn(input bit is_ls, input bit we, input logic [63:0] a, input logic [1:0] sz,
                         input bit uns, input logic [63:0] wd, input int gdly, input int rdly, output obs_t ob);
    int t, gc, gk;
    bit granted, got;
    ob = '{default: '0};
    granted = 0; got = 0; gc = gdly; gk = 0; t = 0;
    if (is_ls) begin
      ls_req = 1; ls_we = we; ls_addr = a; ls_size = sz; ls_unsigned = uns; ls_wdata = wd;
    end else begin
      if_req = 1; if_addr = a;
    end
    #1;
    while (!(is_ls ? ls_ready : if_ready)) begin
      if (t == 20) begin ob.timeout = 1; break; end
      @(posedge clk); #1; t++;
    end
    @(posedge clk); #1;
    ls_req = 0; if_req = 0;
    ls_addr = {$urandom, $urandom}; ls_wdata = {$urandom, $urandom}; if_addr = {$urandom, $urandom};
    ls_size = 2'($urandom); ls_we = 1'($urandom); ls_unsigned = 1'($urandom);
    if (ob.timeout) return;
    for (int k = 1; k <= 80; k++) begin
      if (if_ready || ls_ready) ob.busy_ready = 1;
      if (is_ls ? if_rvalid : ls_rvalid) ob.other_rv = 1;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = {$urandom, $urandom};
      if (is_ls ? ls_rvalid : if_rvalid) begin
        got = 1; ob.lat = k; ob.err = is_ls ? ls_err : if_err;
        ob.rdata = is_ls ? ls_rdata : {32'h0, if_rdata};
        if_req = 0; ls_req = 0;
        break;
      end
      if (mem_req && !granted) begin
        if (!ob.mem_seen) begin
          ob.mem_seen = 1; ob.be = mem_be; ob.wd = mem_wdata; ob.maddr = mem_addr; ob.mwe = mem_we;
        end else if ({mem_be, mem_wdata, mem_addr, mem_we} !== {ob.be, ob.wd, ob.maddr, ob.mwe}) begin
          ob.unstable = 1;
        end
        if (gc == 0) begin mem_gnt = 1; granted = 1; gk = k; end
        else gc--;
      end else if (granted && !(is_ls && we) && k == gk + rdly) begin
        mem_rvalid = 1; mem_rdata = word_at(ob.maddr[3:0]);
      end
      // The other requester keeps asking while busy; it must not see ready.
      if (is_ls) if_req = 1; else ls_req = 1;
      @(posedge clk); #1;
    end
    if (!got) begin ob.timeout = 1; if_req = 0; ls_req = 0; mem_gnt = 0; mem_rvalid = 0; end
    @(posedge clk); #1;
    ob.rv_after = is_ls ? ls_rvalid : if_rvalid;
  endtask

  task automatic test_reset;
    rst_n = 0; if_req = 1; ls_req = 1; ls_size = 2'd3; ls_addr = 64'h8;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (all_out !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    if_req = 0; ls_req = 0;
    @(posedge clk); #1; rst_n = 1; #1;
    n_vec++; if (all_out !== '0) begin n_bad++; $display("FAIL idle_outputs: got %h want 0", all_out); end
    $display("reset: outputs checked in and after reset");
  endtask

  task automatic test_load_format;
    logic [63:0] ta [4];
    logic [1:0]  ts [4];
    bit          tu [4];
    logic [63:0] te [4];
    obs_t ob;
    int gd, rd;
    ta = '{64'd3, 64'd6, 64'd6, 64'd4};
    ts = '{2'd0, 2'd1, 2'd1, 2'd2};
    tu = '{1'b0, 1'b0, 1'b1, 1'b0};
    te = '{64'h44, 64'hFFFF_FFFF_FFFF_8877, 64'h8877, 64'hFFFF_FFFF_8877_6655};
    set_word(0, 64'h8877_6655_4433_2211);
    for (int i = 0; i < 4; i++) begin
      gd = $urandom_range(0, 5); rd = $urandom_range(1, 5);
      run_txn(1, 0, ta[i], ts[i], tu[i], 64'd0, gd, rd, ob);
      $display("load addr=%0d size=%0d uns=%0d rdata=%h lat=%0d", ta[i], ts[i], tu[i], ob.rdata, ob.lat);
      n_vec++; if ({ob.timeout, ob.err, ob.rdata} !== {1'b0, 1'b0, te[i]}) begin
        n_bad++; $display("FAIL load_fmt[%0d]: got %h err=%b want %h", i, ob.rdata, ob.err, te[i]); end
      n_vec++; if (ob.lat !== gd + rd + 2) begin
        n_bad++; $display("FAIL load_lat[%0d]: got %0d want %0d", i, ob.lat, gd + rd + 2); end
    end
  endtask

  task automatic test_store_lanes;
    obs_t ob;
    int gd;
    gd = $urandom_range(0, 5);
    run_txn(1, 1, 64'd5, 2'd0, 0, 64'h1122_3344_5566_77AB, gd, 1, ob);
    $display("store SB addr=5 be=%h wdata=%h lat=%0d", ob.be, ob.wd, ob.lat);
    n_vec++; if ({ob.mwe, ob.be, ob.wd} !== {1'b1, 8'h20, 64'h0000_AB00_0000_0000}) begin
      n_bad++; $display("FAIL sb_lanes: got we=%b be=%h wd=%h want we=1 be=20 wd=0000ab0000000000", ob.mwe, ob.be, ob.wd); end
    n_vec++; if ({ob.lat, ob.err, ob.rdata, ob.rv_after} !== {gd + 2, 1'b0, 64'd0, 1'b0}) begin
      n_bad++; $display("FAIL sb_resp: got lat=%0d err=%b rdata=%h after=%b want lat=%0d", ob.lat, ob.err, ob.rdata, ob.rv_after, gd + 2); end
    apply_store(64'd5, 2'd0, 64'hAB);
    gd = 0;
    run_txn(1, 1, 64'd4, 2'd2, 0, 64'hCAFE_F00D_1234_5678, gd, 1, ob);
    $display("store SW addr=4 be=%h wdata=%h lat=%0d", ob.be, ob.wd, ob.lat);
    n_vec++; if ({ob.be, ob.wd} !== {8'hF0, 64'h1234_5678_0000_0000}) begin
      n_bad++; $display("FAIL sw_lanes: got be=%h wd=%h want be=f0 wd=1234567800000000", ob.be, ob.wd); end
    n_vec++; if (ob.lat !== 2) begin n_bad++; $display("FAIL sw_min_lat: got %0d want 2", ob.lat); end
    apply_store(64'd4, 2'd2, 64'h1234_5678);
  endtask

  task automatic test_misaligned;
    obs_t ob;
    bit          tl [3];
    logic [63:0] ta [3];
    logic [1:0]  ts [3];
    tl = '{1'b1, 1'b1, 1'b0};
    ta = '{64'd2, 64'd4, 64'd6};
    ts = '{2'd2, 2'd3, 2'd2};
    for (int i = 0; i < 3; i++) begin
      run_txn(tl[i], 0, ta[i], ts[i], 0, 64'd0, 0, 1, ob);
      $display("misaligned ls=%0d addr=%0d err=%b lat=%0d mem_req=%b", tl[i], ta[i], ob.err, ob.lat, ob.mem_seen);
      n_vec++; if ({ob.timeout, ob.err, ob.rdata, ob.mem_seen, ob.lat, ob.other_rv} !== {1'b0, 1'b1, 64'd0, 1'b0, 1, 1'b0}) begin
        n_bad++; $display("FAIL misaligned[%0d]: got err=%b rdata=%h mem=%b lat=%0d want err=1 rdata=0 mem=0 lat=1", i, ob.err, ob.rdata, ob.mem_seen, ob.lat); end
    end
  endtask

  task automatic test_fetch;
    obs_t ob;
    set_word(0, 64'hDEAD_BEEF_0000_0013);
    run_txn(0, 0, 64'h1004, 2'd0, 0, 64'd0, 2, 3, ob);
    $display("fetch addr=1004 rdata=%h maddr=%h lat=%0d", ob.rdata, ob.maddr, ob.lat);
    n_vec++; if ({ob.err, ob.rdata, ob.maddr, ob.lat} !== {1'b0, 64'hDEAD_BEEF, 61'h200, 7}) begin
      n_bad++; $display("FAIL fetch_hi: got rdata=%h maddr=%h lat=%0d want deadbeef 200 7", ob.rdata, ob.maddr, ob.lat); end
    run_txn(0, 0, 64'h1000, 2'd0, 0, 64'd0, 0, 1, ob);
    $display("fetch addr=1000 rdata=%h", ob.rdata);
    n_vec++; if ({ob.err, ob.rdata, ob.other_rv, ob.busy_ready} !== {1'b0, 64'h13, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL fetch_lo: got rdata=%h other=%b busy=%b want 13", ob.rdata, ob.other_rv, ob.busy_ready); end
  endtask

  task automatic test_starvation;
    int order[$];
    bit both, gp;
    int cnt, expv;
    both = 0; gp = 0;
    if_addr = 64'h40; ls_we = 0; ls_addr = 64'h48; ls_size = 2'd3; ls_unsigned = 0;
    if_req = 1; ls_req = 1; #1;
    for (int c = 0; c < 300 && order.size() < 10; c++) begin
      if (if_ready && ls_ready) both = 1;
      if (ls_ready) order.push_back(1);
      else if (if_ready) order.push_back(0);
      mem_rvalid = gp; mem_rdata = {$urandom, $urandom}; gp = mem_req; mem_gnt = mem_req;
      @(posedge clk); #1;
    end
    if_req = 0; ls_req = 0;
    repeat (8) begin
      mem_rvalid = gp; gp = mem_req; mem_gnt = mem_req;
      @(posedge clk); #1;
    end
    mem_gnt = 0; mem_rvalid = 0;
    $display("starvation: %0d grants observed (1=LS 0=IF): %p", order.size(), order);
    n_vec++; if ({order.size() == 10, both} !== 2'b10) begin
      n_bad++; $display("FAIL starve_count: got %0d grants both=%b want 10 grants both=0", order.size(), both); end
    cnt = 0;
    for (int i = 0; i < order.size(); i++) begin
      expv = (cnt == LIM) ? 0 : 1;
      cnt = expv ? cnt + 1 : 0;
      n_vec++; if (order[i] !== expv) begin
        n_bad++; $display("FAIL starve_order[%0d]: got %0d want %0d", i, order[i], expv); end
    end
  endtask

  task automatic test_random;
    obs_t ob;
    bit is_ls, we, uns, mis;
    logic [63:0] a, wd, er;
    logic [1:0] sz;
    int gd, rd, el;
    for (int n = 0; n < 40; n++) begin
      is_ls = ($urandom_range(0, 9) < 7);
      we    = is_ls && 1'($urandom);
      uns   = 1'($urandom);
      sz    = is_ls ? 2'($urandom) : 2'd2;
      a     = {$urandom, $urandom};
      wd    = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a[2:0] = is_ls ? (a[2:0] & ~3'((1 << sz) - 1)) : {a[2], 2'b00};
      gd = $urandom_range(0, 5); rd = $urandom_range(1, 5);
      mis = ref_mis(is_ls, a, sz);
      er  = (mis || we) ? 64'd0 : (is_ls ? ref_load(a, sz, uns) : ref_load(a, 2'd2, 1'b1));
      el  = mis ? 1 : (we ? gd + 2 : gd + rd + 2);
      run_txn(is_ls, we, a, sz, uns, wd, gd, rd, ob);
      $display("rand[%0d] %s we=%0d addr=%h size=%0d rdata=%h err=%b lat=%0d", n, is_ls ? "LS" : "IF", we, a, sz, ob.rdata, ob.err, ob.lat);
      n_vec++; if ({ob.timeout, ob.err, ob.rdata} !== {1'b0, mis, er}) begin
        n_bad++; $display("FAIL rand_data[%0d]: got to=%b err=%b rdata=%h want err=%b rdata=%h", n, ob.timeout, ob.err, ob.rdata, mis, er); end
      n_vec++; if (ob.lat !== el) begin n_bad++; $display("FAIL rand_lat[%0d]: got %0d want %0d", n, ob.lat, el); end
      n_vec++; if ({ob.other_rv, ob.busy_ready, ob.unstable, ob.rv_after} !== 4'b0000) begin
        n_bad++; $display("FAIL rand_proto[%0d]: got other=%b busy_ready=%b unstable=%b rv_after=%b want 0000", n, ob.other_rv, ob.busy_ready, ob.unstable, ob.rv_after); end
      n_vec++;
      if (mis) begin
        if (ob.mem_seen !== 1'b0) begin n_bad++; $display("FAIL rand_nomem[%0d]: got mem_req=1 want 0", n); end
      end else if ({ob.mem_seen, ob.maddr, ob.mwe, ob.be} !== {1'b1, a[63:3], we, we ? ref_be(a, sz) : 8'hFF}) begin
        n_bad++; $display("FAIL rand_mem[%0d]: got addr=%h we=%b be=%h want addr=%h we=%b", n, ob.maddr, ob.mwe, ob.be, a[63:3], we);
      end
      if (we && !mis) begin
        n_vec++; if (ob.wd !== ref_wd(a, sz, wd)) begin
          n_bad++; $display("FAIL rand_wdata[%0d]: got %h want %h", n, ob.wd, ref_wd(a, sz, wd)); end
        apply_store(a, sz, wd);
      end
    end
  endtask

  task automatic test_reset_midflight;
    obs_t ob;
    int t1, t2;
    bit seen;
    ls_req = 1; ls_we = 0; ls_addr = 64'h18; ls_size = 2'd3; ls_unsigned = 0; #1;
    t1 = 0; while (!ls_ready && t1 < 20) begin @(posedge clk); #1; t1++; end
    @(posedge clk); #1; ls_req = 0;
    t2 = 0; while (!mem_req && t2 < 20) begin @(posedge clk); #1; t2++; end
    mem_gnt = 1; @(posedge clk); #1; mem_gnt = 0;
    @(posedge clk); #1;
    rst_n = 0; #1;
    n_vec++; if ({t1 < 20, t2 < 20, all_out} !== {2'b11, 237'd0}) begin
      n_bad++; $display("FAIL midflight_reset: got wait_ok=%b%b outs=%h want 11 and 0", t1 < 20, t2 < 20, all_out); end
    @(posedge clk); #1; rst_n = 1;
    mem_rvalid = 1; mem_rdata = {$urandom, $urandom};
    @(posedge clk); #1; mem_rvalid = 0;
    seen = 0;
    repeat (4) begin if (ls_rvalid || if_rvalid) seen = 1; @(posedge clk); #1; end
    n_vec++; if (seen !== 1'b0) begin n_bad++; $display("FAIL late_rvalid: got response=1 want 0"); end
    run_txn(1, 0, 64'h18, 2'd3, 0, 64'd0, 1, 2, ob);
    $display("after reset: load addr=18 rdata=%h lat=%0d", ob.rdata, ob.lat);
    n_vec++; if ({ob.err, ob.rdata, ob.lat} !== {1'b0, ref_load(64'h18, 2'd3, 1'b0), 5}) begin
      n_bad++; $display("FAIL post_reset_load: got rdata=%h lat=%0d want %h lat=5", ob.rdata, ob.lat, ref_load(64'h18, 2'd3, 1'b0)); end
  endtask

  initial begin
    if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0; ls_size = '0;
    ls_unsigned = 0; ls_wdata = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    for (int i = 0; i < 128; i++) mem_b[i] = 8'($urandom);
    test_reset();
    test_load_format();
    test_store_lanes();
    test_misaligned();
    test_fetch();
    test_starvation();
    test_random();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares a single 64-bit word-addressed data memory port between two requesters: instruction fetch (IF) and the load/store unit (LS).
- Arbitrates between them with fixed LS priority plus a starvation guard for IF.
- Handles one transaction at a time.
- Performs byte-lane alignment, masking and sign extension for RV64 B/H/W/D accesses, using the same byte semantics as the ISA reference model.

Parameters:
- STARVE_LIM, 4: max consecutive LS grants while IF is waiting; IF is then forced. Must be ≥1.
- CNT_W, 3: width of the starvation counter. Must hold STARVE_LIM.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr until if_ready
- if_addr  in  64  byte address of 32-bit instruction
- if_ready  out  1  request accepted this cycle
- if_rvalid  out  1  fetch response, 1-cycle pulse
- if_rdata  out  32  fetched instruction
- if_err  out  1  misaligned fetch; valid with if_rvalid
- ls_req  in  1  load/store request; held with attributes until ls_ready
- ls_we  in  1  1=store, 0=load
- ls_addr  in  64  byte address
- ls_size  in  2  0=B, 1=H, 2=W, 3=D
- ls_unsigned  in  1  zero-extend load (ignored for D and stores)
- ls_wdata  in  64  store data, right-aligned
- ls_ready  out  1  request accepted this cycle
- ls_rvalid  out  1  response pulse (load data or store ack)
- ls_rdata  out  64  extended load data; 0 for stores and errors
- ls_err  out  1  misaligned access; valid with ls_rvalid
- mem_req  out  1  memory request, held until mem_gnt
- mem_we  out  1  write enable
- mem_addr  out  61  word index = byte_addr[63:3]
- mem_be  out  8  byte enables (write only; 8'hFF on reads)
- mem_wdata  out  64  lane-shifted write data
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid; any latency ≥1 after mem_gnt
- mem_rdata  in  64  read word

Behaviour:
- Reset (async, rst_n=0): state=IDLE, starvation cnt=0, all outputs 0, captured request cleared.
- Reset mid-transaction abandons it. No response is ever issued for the abandoned request. mem_rvalid is ignored in IDLE.
- FSM states: IDLE, ERR, REQ, WAIT_R, RESP.
- IDLE → ERR / REQ (acceptance):
  - Select LS if ls_req, unless if_req && cnt==STARVE_LIM, in which case select IF. Select IF if only if_req.
  - The winner's ready output is combinational, high this cycle. Capture addr/size/we/unsigned/wdata and the owner.
  - Misaligned = LS: addr[2:0] not a multiple of 2^size; IF: addr[1:0]≠0.
  - Misaligned → ERR. Otherwise → REQ.
- Starvation counter, updated on acceptance:
  - LS grant with if_req high → cnt+1, saturating.
  - LS grant with if_req low, or any IF grant → cnt=0.
- ERR: the owner's rvalid=1 and err=1, rdata=0, for 1 cycle → IDLE. No memory access is made.
- REQ: mem_req=1 with registered mem_addr/mem_we/mem_be/mem_wdata, stable until mem_gnt.
  - On mem_gnt: store → RESP; read → WAIT_R.
- WAIT_R: on mem_rvalid, register the formatted data → RESP.
- RESP: owner's rvalid=1 for exactly 1 cycle, err=0 → IDLE.
  - Next acceptance is earliest in the following cycle. Ready is never asserted outside IDLE.
- Latency (aligned, ready to rvalid), with gnt at cycle g and mem_rvalid at cycle r:
  - Store: rvalid at g+1.
  - Read: rvalid at r+1.
  - Minimum store: 2 cycles after ready.
- Store lanes, with n = 2^size and o = addr[2:0]:
  - mem_be = ((1<<n)-1) << o.
  - mem_wdata = (ls_wdata & low-n-byte mask) << 8*o.
  - Aligned accesses never straddle a word.
- Load formatting: v = (mem_rdata >> 8*o), masked to n bytes.
  - Sign-extend from bit 8n-1 unless ls_unsigned or size=D.
- IF formatting: if_rdata = addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
- Address bits above 63 are not used; no wrap checking (word index is a plain truncation).
- Simultaneous if_req and ls_req in a non-IDLE state: both are held; there is no ready and no loss.
- Responses go to the captured owner only. The other requester's rvalid stays 0.

Test Plan:
- Word 0 = 0x8877665544332211. LS load B, addr 3, signed → ls_rdata=0x44. Load H, addr 6, signed → 0xFFFFFFFFFFFF8877. LH unsigned → 0x8877. Load W, addr 4 → 0xFFFFFFFF88776655.
- SB 0xAB to addr 5 → mem_be=8'h20, mem_wdata=0x0000AB0000000000. SW 0x12345678 to addr 4 → mem_be=8'hF0. ls_rvalid exactly 1 cycle after mem_gnt.
- Misaligned LS: LW at addr 2 and LD at addr 4 → mem_req stays 0, ls_rvalid=ls_err=1 one cycle after ls_ready, ls_rdata=0. IF at addr 6 → if_err=1.
- if_req and ls_req held continuously with STARVE_LIM=4 → grant order LS,LS,LS,LS,IF,LS,…
- IF at addr 0x1004 with mem_rdata=0xDEADBEEF_00000013 → if_rdata=0xDEADBEEF.
- Inject mem_gnt/mem_rvalid with random 0–5 cycle delays: responses are in order, one outstanding, and no ready outside IDLE.
- Assert rst_n low while in WAIT_R: outputs go to 0 immediately. A late mem_rvalid produces no rvalid. The next request is served normally.
